// File: rtl/wb_stage_if.sv
// MEM -> WB bundle.
// Carries one instruction from the MEM stage into the writeback stage.
//   mem_valid      : MEM holds a valid instruction
//   mem_reg_write  : instruction writes a GPR
//   mem_rd         : destination register number
//   mem_wb_sel     : 00 ALU, 01 load, 10 link, 11 reserved (acts as ALU)
//   mem_alu_result : ALU result / effective address
//   mem_load_data  : raw word read from data memory
//   mem_link_pc    : return address for JAL/JALR
//   mem_load_type  : 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, others LW
interface wb_stage_if;
    logic        mem_valid;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_load_data;
    logic [31:0] mem_link_pc;
    logic [2:0]  mem_load_type;

    modport master (
        output mem_valid, mem_reg_write, mem_rd, mem_wb_sel,
               mem_alu_result, mem_load_data, mem_link_pc, mem_load_type
    );

    modport slave (
        input  mem_valid, mem_reg_write, mem_rd, mem_wb_sel,
               mem_alu_result, mem_load_data, mem_link_pc, mem_load_type
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: owns the MEM/WB pipeline register, aligns and extends
// load data, selects the writeback source, gates the register-file write
// strobe, bypasses the pending write to the decode-stage operand reads and
// counts retired instructions.
// Ports:
//   clock, reset_n            : clock, asynchronous active-low reset
//   mem                       : MEM stage instruction bundle (slave side)
//   stall, flush              : insert bubble / kill entering instruction
//   cnt_clr                   : synchronous clear of the retire counter
//   id_rs_*/id_rt_*           : decode read addresses, RF data, bypassed data
//   WB_address_wr/_data_wb/_write : register file write port
//   misalign_err              : WB instruction is a misaligned load
//   retired_cnt               : retired instruction count (wraps)
module wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    wb_stage_if.slave        mem,
    input  logic             stall,
    input  logic             flush,
    input  logic             cnt_clr,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic [31:0]      id_rs_data,
    input  logic [31:0]      id_rt_data,
    output logic [31:0]      id_rs_fwd,
    output logic [31:0]      id_rt_fwd,
    output logic [4:0]       WB_address_wr,
    output logic [31:0]      WB_data_wb,
    output logic             WB_write,
    output logic             misalign_err,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LHU = 3'b010;
    localparam logic [2:0] LT_LB  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;

    logic             valid_q,     valid_d;
    logic             reg_write_q, reg_write_d;
    logic [4:0]       rd_q,        rd_d;
    logic [1:0]       sel_q,       sel_d;
    logic [31:0]      alu_q,       alu_d;
    logic [31:0]      load_q,      load_d;
    logic [31:0]      link_q,      link_d;
    logic [2:0]       ltype_q,     ltype_d;
    logic [1:0]       addr_lo_q,   addr_lo_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    logic             capture;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_aligned;
    logic             misalign_cond;
    logic             misalign;

    // Fields only move on a real capture; a bubble clears valid but leaves
    // the last captured fields visible on the data/address outputs.
    assign capture = !flush && !stall;

    always_comb begin
        valid_d     = 1'b0;
        reg_write_d = reg_write_q;
        rd_d        = rd_q;
        sel_d       = sel_q;
        alu_d       = alu_q;
        load_d      = load_q;
        link_d      = link_q;
        ltype_d     = ltype_q;
        addr_lo_d   = addr_lo_q;
        if (capture) begin
            valid_d     = mem.mem_valid;
            reg_write_d = mem.mem_reg_write;
            rd_d        = mem.mem_rd;
            sel_d       = mem.mem_wb_sel;
            alu_d       = mem.mem_alu_result;
            load_d      = mem.mem_load_data;
            link_d      = mem.mem_link_pc;
            ltype_d     = mem.mem_load_type;
            addr_lo_d   = mem.mem_alu_result[1:0];
        end
    end

    // Clear wins over a simultaneous retire.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (valid_q) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            sel_q       <= '0;
            alu_q       <= '0;
            load_q      <= '0;
            link_q      <= '0;
            ltype_q     <= '0;
            addr_lo_q   <= '0;
            cnt_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            sel_q       <= sel_d;
            alu_q       <= alu_d;
            load_q      <= load_d;
            link_q      <= link_d;
            ltype_q     <= ltype_d;
            addr_lo_q   <= addr_lo_d;
            cnt_q       <= cnt_d;
        end
    end

    // Little-endian lane selection.
    always_comb begin
        case (addr_lo_q)
            2'd0:    byte_sel = load_q[7:0];
            2'd1:    byte_sel = load_q[15:8];
            2'd2:    byte_sel = load_q[23:16];
            default: byte_sel = load_q[31:24];
        endcase
        half_sel = addr_lo_q[1] ? load_q[31:16] : load_q[15:0];
    end

    always_comb begin
        case (ltype_q)
            LT_LH:   load_aligned = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  load_aligned = {16'h0000, half_sel};
            LT_LB:   load_aligned = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  load_aligned = {24'h000000, byte_sel};
            default: load_aligned = load_q;
        endcase
    end

    always_comb begin
        case (ltype_q)
            LT_LH, LT_LHU: misalign_cond = addr_lo_q[0];
            LT_LB, LT_LBU: misalign_cond = 1'b0;
            default:       misalign_cond = (addr_lo_q != 2'b00);
        endcase
    end

    assign misalign = valid_q && (sel_q == SEL_LOAD) && misalign_cond;

    always_comb begin
        case (sel_q)
            SEL_LOAD: WB_data_wb = load_aligned;
            SEL_LINK: WB_data_wb = link_q;
            default:  WB_data_wb = alu_q;
        endcase
    end

    // rd==0 is excluded here, which also keeps r0 out of the bypass below.
    assign WB_write      = valid_q && reg_write_q && (rd_q != 5'd0) && !misalign;
    assign WB_address_wr = rd_q;
    assign misalign_err  = misalign;
    assign retired_cnt   = cnt_q;

    // The RF writes on the next edge, so a same-cycle read sees stale data.
    assign id_rs_fwd = (WB_write && (id_rs_addr == WB_address_wr)) ? WB_data_wb : id_rs_data;
    assign id_rt_fwd = (WB_write && (id_rt_addr == WB_address_wr)) ? WB_data_wb : id_rt_data;

endmodule
